apb_completer: RTL
==================

# apb_completer

APB completer (responder) that terminates APB transfers issued by an APB requester such as the APB bridge and converts them into single-cycle strobes on the team's synchronous memory interface. It decodes a word-addressed window and inserts a configurable number of wait states. It returns read data or a slave error on PREADY/PSLVERR. It sits between the APB fabric and `apb_mem`, replacing direct memory hookup so the requester sees protocol-correct handshakes.

## Interface
- `ADDR_WIDTH`, 32: APB and memory address width (word address).
- `DATA_WIDTH`, 32: data width.
- `STRB_SIZE`, `DATA_WIDTH/8`: byte strobe width.
- `BASE_ADDR`, 32'h0000_0000: first decoded word address.
- `MEM_WORDS`, 256: number of decoded words.
- `WAIT_CYCLES`, 0: extra access-phase wait states before the memory strobe. Legal range 0..15.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `psel`, in, 1: APB select.
- `penable`, in, 1: APB access phase.
- `pwrite`, in, 1: 1 = write, 0 = read.
- `paddr`, in, ADDR_WIDTH: word address.
- `pwdata`, in, DATA_WIDTH: write data.
- `pstrb`, in, STRB_SIZE: write byte strobes.
- `prdata`, out, DATA_WIDTH: read data, valid when `pready`.
- `pready`, out, 1: transfer completion.
- `pslverr`, out, 1: error response, valid only with `pready`.
- `mem_wr`, out, 1: memory write strobe.
- `mem_rd`, out, 1: memory read strobe.
- `mem_be`, out, STRB_SIZE: memory byte enables.
- `mem_address`, out, ADDR_WIDTH: `paddr - BASE_ADDR`.
- `mem_data_in`, out, DATA_WIDTH: memory write data.
- `mem_data_out`, in, DATA_WIDTH: memory read data, valid one cycle after `mem_rd`.

## Operation
- States:
  - IDLE: accepts a request.
  - WAIT: counts down wait states.
  - MEM: issues the memory strobe.
  - CAPT: captures read data; reads only.
  - RESP: drives `pready` for exactly one cycle.
- IDLE, `psel & ~penable` sampled:
  - Latches `pwrite`, `paddr`, `pwdata` and `pstrb`.
  - Decodes the address.
- Out-of-range request (`paddr < BASE_ADDR` or `paddr >= BASE_ADDR+MEM_WORDS`):
  - Goes directly to RESP with `pslverr=1` and `prdata=0`.
  - Never asserts `mem_wr` or `mem_rd`.
- In-range request:
  - Goes to WAIT with counter = `WAIT_CYCLES`.
  - When `WAIT_CYCLES==0`, goes straight to MEM.
- WAIT: decrements the counter each cycle and enters MEM on the cycle it reaches 0.
- MEM, write:
  - `mem_wr=1`, `mem_be=pstrb`, `mem_data_in=pwdata`.
  - Next state is RESP.
  - A write with `pstrb==0` still completes OKAY, with `mem_be=0`.
- MEM, read:
  - `mem_rd=1`, `mem_be` all ones.
  - Next state is CAPT.
- CAPT: registers `mem_data_out` into `prdata`, then goes to RESP.
- RESP:
  - `pready=1`.
  - `prdata` holds captured data for reads and 0 for writes and errors.
  - Returns to IDLE unconditionally.
- `psel` deasserted in WAIT, MEM or CAPT (requester abort):
  - Returns to IDLE next cycle, with no `pready`.
  - Drops a pending strobe if still in WAIT.
  - A strobe already issued in MEM is not undone.
- `penable` high while IDLE (protocol violation): ignored, no state change.
- All outputs are decoded from registered state/latches; there is no combinational path from APB inputs to outputs.

## Timing
- Reset values while `rst_n=0` at a clock edge: state IDLE, all outputs 0 (`prdata`, `pready`, `pslverr`, `mem_wr`, `mem_rd`, `mem_be`, `mem_address`, `mem_data_in`).
- Reset mid-transfer aborts immediately; no completion is reported.
- Cycle numbering: c0 = setup cycle.
- Write timing:
  - `mem_wr` is high in c(1+W).
  - `pready` is high in c(2+W).
- Read timing:
  - `mem_rd` is high in c(1+W).
  - `pready` and `prdata` are valid in c(3+W).
- Error timing: `pready` and `pslverr` are high in c1.
- `mem_wr`, `mem_rd` and `pready` are each exactly one cycle wide.
- Back-to-back: the next setup may occur the cycle after RESP and is accepted normally. Maximum throughput is one write per 3 cycles at W=0.
- `mem_address` is a width-truncated subtraction and is only meaningful for in-range requests.

## Structure
- `apb_completer_pkg` holds:
  - the `state_t` enum (IDLE, WAIT, MEM, CAPT, RESP);
  - `RESP_OKAY`/`RESP_ERR` constants;
  - the wait-counter width function `$clog2(WAIT_CYCLES+1)`.
- One sub-module, `apb_cmpl_decode`:
  - purely combinational range check plus offset subtraction;
  - outputs `hit` and `offset`;
  - reusable for multi-region completers.

## Test plan
- **Write.** W=0; write `paddr=0x0F0`, `pwdata=0x000A_3210`, `pstrb=4'hF`.
  - c1: `mem_wr=1`, `mem_address=0x0F0`, `mem_be=4'hF`.
  - c2: `pready=1`, `pslverr=0`.
- **Read back.** Read 0x0F0.
  - c1: `mem_rd=1`.
  - c3: `pready=1`, `prdata=0x000A_3210`.
  - Repeat over 0x0F0..0x0F9 with data `0x000A_3210+i`.
- **Byte strobes.** Write 0x1234_5678 to 0x0F1, then write 0xFFFF_FFFF with `pstrb=4'h3`, then read.
  - Read returns `prdata=0x1234_FFFF`.
- **Out of range.** Read `paddr=0x100` with `MEM_WORDS=256`.
  - c1: `pready=1`, `pslverr=1`, `prdata=0`.
  - `mem_rd` never asserted.
- **Wait states.** `WAIT_CYCLES=3`; write.
  - `mem_wr` in c4, `pready` in c5.
  - A read under the same setting gives `pready` in c6.
- **Abort and reset.**
  - Drop `psel` in WAIT: no `mem_wr`/`mem_rd`/`pready`, and the following transfer completes normally.
  - Assert `rst_n=0` during CAPT: all outputs 0 after the next edge, and no `pready`.

Source files
------------

// File: rtl/apb_completer_pkg.sv
// Shared types and helpers for the APB completer.
//   state_t     - completer FSM encoding
//   RESP_OKAY   - pslverr value for a successful transfer
//   RESP_ERR    - pslverr value for a decode error
//   cnt_width() - width of the wait-state counter for a given wait count
package apb_completer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StMem,
        StCapt,
        StResp
    } state_t;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    // A zero-wait configuration still needs a 1-bit counter to keep the vector legal.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/apb_cmpl_decode.sv
// Combinational window decoder for an APB completer.
//   addr   - incoming word address
//   hit    - addr lies in [BASE_ADDR, BASE_ADDR + MEM_WORDS)
//   offset - addr - BASE_ADDR, truncated to ADDR_WIDTH (meaningful only on hit)
module apb_cmpl_decode #(
    parameter int unsigned              ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0,
    parameter int unsigned              MEM_WORDS  = 256
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [ADDR_WIDTH-1:0] offset
);

    // One extra bit so a window reaching the top of the address space still compares correctly.
    localparam logic [ADDR_WIDTH:0] Limit = (ADDR_WIDTH + 1)'(MEM_WORDS);

    always_comb begin
        offset = addr - BASE_ADDR;
        // Comparing the offset avoids overflow in BASE_ADDR + MEM_WORDS.
        hit    = (addr >= BASE_ADDR) && ({1'b0, offset} < Limit);
    end

endmodule

// File: rtl/apb_completer.sv
// APB completer terminating transfers onto a single-cycle synchronous memory port.
//   clk, rst_n                - clock and synchronous active-low reset
//   psel, penable, pwrite     - APB control
//   paddr, pwdata, pstrb      - APB word address, write data, byte strobes
//   prdata, pready, pslverr   - APB response (registered)
//   mem_wr, mem_rd, mem_be    - memory strobes and byte enables
//   mem_address, mem_data_in  - memory offset address and write data
//   mem_data_out              - memory read data, valid one cycle after mem_rd
module apb_completer
    import apb_completer_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           STRB_SIZE   = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           MEM_WORDS   = 256,
    parameter int unsigned           WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_SIZE-1:0]  pstrb,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [STRB_SIZE-1:0]  mem_be,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam int unsigned CntW = cnt_width(WAIT_CYCLES);
    // The counter holds the number of WAIT cycles still to spend after the current one.
    localparam logic [CntW-1:0] CntLoad = (WAIT_CYCLES == 0) ? '0 : CntW'(WAIT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_SIZE-1:0]  strb_q, strb_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  dec_hit;
    logic [ADDR_WIDTH-1:0] dec_offset;

    apb_cmpl_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .MEM_WORDS  (MEM_WORDS)
    ) u_decode (
        .addr   (paddr),
        .hit    (dec_hit),
        .offset (dec_offset)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        err_d    = err_q;
        offset_d = offset_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        prdata_d = prdata_q;

        unique case (state_q)
            StIdle: begin
                // penable without a preceding setup phase is ignored.
                if (psel && !penable) begin
                    write_d  = pwrite;
                    wdata_d  = pwdata;
                    strb_d   = pstrb;
                    offset_d = dec_offset;
                    prdata_d = '0;
                    if (!dec_hit) begin
                        err_d   = RESP_ERR;
                        state_d = StResp;
                    end else begin
                        err_d = RESP_OKAY;
                        if (WAIT_CYCLES == 0) begin
                            state_d = StMem;
                        end else begin
                            cnt_d   = CntLoad;
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                if (!psel) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StMem;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StMem: begin
                if (!psel) begin
                    state_d = StIdle;
                end else begin
                    state_d = write_q ? StResp : StCapt;
                end
            end
            StCapt: begin
                if (!psel) begin
                    state_d = StIdle;
                end else begin
                    prdata_d = mem_data_out;
                    state_d  = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= RESP_OKAY;
            offset_q <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            err_q    <= err_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            prdata_q <= prdata_d;
        end
    end

    // Outputs depend only on registered state and latched request fields.
    always_comb begin
        pready      = (state_q == StResp);
        pslverr     = (state_q == StResp) && (err_q == RESP_ERR);
        mem_wr      = (state_q == StMem) && write_q;
        mem_rd      = (state_q == StMem) && !write_q;
        mem_be      = '0;
        if (state_q == StMem) begin
            mem_be = write_q ? strb_q : '1;
        end
        mem_address = offset_q;
        mem_data_in = wdata_q;
        prdata      = prdata_q;
    end

endmodule
